// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader:
// FSM state encoding and the default IM geometry.
package im_loader_pkg;

    localparam int IM_ADDR_WIDTH = 10;
    localparam int IM_DEPTH      = 1 << IM_ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR_HI = 3'd1,
        HDR_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_e;

endpackage

// File: rtl/im_word_packer.sv
// Packs four bytes, MSB first, into a 32-bit word.
// word_ready flags the cycle in which the 4th byte arrives.
module im_word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear) begin
            cnt_d = 2'd0;
        end else if (byte_valid) begin
            word_d = {word_q[23:0], byte_data};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    // The finished word is presented combinationally so the write
    // can be registered on the same edge that takes the 4th byte.
    assign word_ready = byte_valid && !clear && (cnt_q == 2'd3);
    assign word       = {word_q[23:0], byte_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/im_loader.sv
// Byte-stream program loader for instruction memory; keeps the CPU
// held in reset until a checksum-valid program has been written.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = IM_ADDR_WIDTH,
    parameter int BASE_WORD  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_hold
);

    localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BASE_IDX = ADDR_WIDTH'(BASE_WORD);

    state_e                  state_q, state_d;
    logic [7:0]              hdr_q, hdr_d;
    logic [15:0]             words_q, words_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [7:0]              sum_q, sum_d;
    logic                    mem_we_q, mem_we_d;
    logic [31:0]             mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;

    logic        accept;
    logic        pk_clear;
    logic        pk_valid;
    logic        pk_ready;
    logic [31:0] pk_word;
    logic [15:0] n_full;
    logic [7:0]  sum_next;
    logic        too_big;

    im_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_data  (in_data),
        .word_ready (pk_ready),
        .word       (pk_word)
    );

    assign busy = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                  (state_q == DATA)   || (state_q == CSUM);

    // Stall the link while a write is out so only one is ever pending.
    assign in_ready = busy && !mem_we_q;
    assign accept   = in_valid && in_ready;
    assign n_full   = {hdr_q, in_data};
    assign sum_next = sum_q + in_data;
    assign too_big  = (33'(BASE_WORD) + 33'(n_full)) > DEPTH;

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        words_d     = words_q;
        idx_d       = idx_q;
        sum_d       = sum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = done_q;
        error_d     = error_q;
        pk_clear    = 1'b0;
        pk_valid    = 1'b0;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d  = HDR_HI;
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                    sum_d    = 8'd0;
                    idx_d    = BASE_IDX;
                    pk_clear = 1'b1;
                end
            end
            HDR_HI: begin
                if (accept) begin
                    hdr_d   = in_data;
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (accept) begin
                    words_d = n_full;
                    if (n_full == 16'd0) begin
                        state_d = CSUM;
                    end else if (too_big) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    sum_d    = sum_next;
                    pk_valid = 1'b1;
                    if (pk_ready) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {{(30-ADDR_WIDTH){1'b0}}, idx_q, 2'b00};
                        mem_wdata_d = pk_word;
                        idx_d       = idx_q + 1'b1;
                        words_d     = words_q - 16'd1;
                        if (words_q == 16'd1) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    if (sum_next == 8'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            hdr_q       <= 8'd0;
            words_q     <= 16'd0;
            idx_q       <= BASE_IDX;
            sum_q       <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            words_q     <= words_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cpu_hold  = busy | error_q | ~done_q;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: the driver queues expected IM
// writes, a negedge monitor pops and checks each mem_we strobe.
module tb_im_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    im_loader #(.ADDR_WIDTH(10), .BASE_WORD(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_hold  (cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] words[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          n_writes = 0;
    int          n_pushed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset && mem_we) begin
            exp_t e;
            n_writes++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_wdata, e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap,
                             input bit push, input logic [31:0] addr,
                             input logic [31:0] data);
        int t;
        exp_t e;
        t = 0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready) begin
            @(negedge clk);
            t++;
            if (t > 50) begin
                checks++;
                failures++;
                $display("FAIL ready_timeout: got in_ready 0 expected 1");
                in_valid = 1'b0;
                return;
            end
        end
        if (push) begin
            e.addr = addr;
            e.data = data;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
            n_pushed++;
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [15:0] n, input bit bad, input int gap_mode);
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [31:0] w;
        sum = 8'd0;
        send_byte(n[15:8], 0, 1'b0, 0, 0);
        send_byte(n[7:0], 0, 1'b0, 0, 0);
        for (int i = 0; i < int'(n); i++) begin
            w = words[i];
            for (int j = 0; j < 4; j++) begin
                b = w[31-8*j -: 8];
                sum += b;
                send_byte(b, gap_mode != 0 ? (i + j) % 3 : 0,
                          j == 3, 32'(i) << 2, w);
            end
        end
        b = 8'd0 - sum;
        if (bad) b = b + 8'd1;
        send_byte(b, 0, 1'b0, 0, 0);
        in_valid = 1'b0;
    endtask

    task automatic do_start(input bit with_byte);
        @(negedge clk);
        start = 1'b1;
        if (with_byte) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done", done, 0);
        chk("start_error", error, 0);
    endtask

    task automatic chk_end(string tag, bit ok);
        chk({tag, "_done"}, done, ok);
        chk({tag, "_error"}, error, !ok);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_hold"}, cpu_hold, !ok);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_hold"}, cpu_hold, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;

        // 1: one word, stray byte alongside start must not be consumed
        words = '{32'h24080005};
        do_start(1'b1);
        send_frame(16'd1, 1'b0, 0);
        chk_end("t1", 1'b1);

        // 2: two words back to back
        words = '{32'h24090007, 32'h012A5021};
        do_start(1'b0);
        send_frame(16'd2, 1'b0, 0);
        chk_end("t2", 1'b1);

        // 3: empty program, good then bad checksum
        do_start(1'b0);
        send_frame(16'd0, 1'b0, 0);
        chk_end("t3a", 1'b1);
        do_start(1'b0);
        send_frame(16'd0, 1'b1, 0);
        chk_end("t3b", 1'b0);

        // 4: 1025 words cannot fit in 1024
        do_start(1'b0);
        send_byte(8'h04, 0, 1'b0, 0, 0);
        send_byte(8'h01, 0, 1'b0, 0, 0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk_end("t4", 1'b0);

        // 5: gapped stream with start pulsed mid-DATA
        words = '{32'hDEADBEEF, 32'h00FF10F0, 32'h8C020004};
        do_start(1'b0);
        fork
            send_frame(16'd3, 1'b0, 1);
            begin
                repeat (8) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("t5_busy_mid", busy, 1);
            end
        join
        chk_end("t5", 1'b1);

        // 6: reset after 2 bytes of the first word, then reload
        do_start(1'b0);
        send_byte(8'h00, 0, 1'b0, 0, 0);
        send_byte(8'h02, 0, 1'b0, 0, 0);
        send_byte(8'h11, 0, 1'b0, 0, 0);
        send_byte(8'h22, 0, 1'b0, 0, 0);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 chk_reset_vals("t6_rst");
        @(negedge clk);
        reset = 1'b0;
        words = '{32'h3C1D1000, 32'h03E00008};
        do_start(1'b0);
        send_frame(16'd2, 1'b0, 0);
        chk_end("t6", 1'b1);

        repeat (3) @(negedge clk);
        chk("write_count", n_writes, n_pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
